lcd_byte_writer: RTL and testbench

Physical-layer driver for the HD44780-compatible character LCD in 4-bit write-only mode. It accepts one byte (or one bare nibble) per valid/ready handshake from the display sequencer upstream. It serialises the byte into high/low nibbles with correct setup, enable-pulse and execution-wait timing on the LCD pins. The sequencer keeps message/cursor logic and its tick pacing, and no longer handles pin timing.

---
 rtl/lcd_pkg.sv | 33 +++
 rtl/lcd_byte_writer_if.sv | 11 +
 rtl/lcd_byte_writer.sv | 132 +++++++++++++
 tb/tb_lcd_byte_writer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared HD44780 definitions: FSM state codes, command constants and the
// power-up init table used by the upstream sequencer.
package lcd_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_HI_SETUP  = 3'd1;
  localparam logic [2:0] ST_HI_PULSE  = 3'd2;
  localparam logic [2:0] ST_GAP       = 3'd3;
  localparam logic [2:0] ST_LO_SETUP  = 3'd4;
  localparam logic [2:0] ST_LO_PULSE  = 3'd5;
  localparam logic [2:0] ST_EXEC_WAIT = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_HI_SETUP  = ST_HI_SETUP,
    S_HI_PULSE  = ST_HI_PULSE,
    S_GAP       = ST_GAP,
    S_LO_SETUP  = ST_LO_SETUP,
    S_LO_PULSE  = ST_LO_PULSE,
    S_EXEC_WAIT = ST_EXEC_WAIT
  } lcd_state_e;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Sequencer init order, first entry in the top byte.
  localparam logic [5:0][7:0] INIT_SEQ = {8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_byte_writer_if.sv
// Byte/nibble request handshake between the display sequencer and the pin driver.
interface lcd_byte_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_rs;
  logic       in_nibble_only;

  modport master (output in_valid, in_data, in_rs, in_nibble_only, input in_ready);
  modport slave  (input in_valid, in_data, in_rs, in_nibble_only, output in_ready);
endinterface

// File: rtl/lcd_byte_writer.sv
// HD44780 4-bit write-only pin driver: serialises one byte (or bare nibble)
// per handshake into timed enable pulses followed by an execution wait.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 2,
  parameter int E_HIGH_CYC     = 12,
  parameter int GAP_CYC        = 50,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic               clk,
  input  logic               reset,
  lcd_byte_writer_if.slave   req,
  output logic               busy,
  output logic               lcd_rs,
  output logic               lcd_rw,
  output logic               lcd_e,
  output logic               lcd_4,
  output logic               lcd_5,
  output logic               lcd_6,
  output logic               lcd_7
);

  localparam int MAXP = max2(max2(max2(SETUP_CYC, E_HIGH_CYC), max2(GAP_CYC, CMD_WAIT_CYC)),
                             CLEAR_WAIT_CYC);
  localparam int CW   = $clog2(MAXP) + 1;

  if (SETUP_CYC < 1 || E_HIGH_CYC < 1 || GAP_CYC < 1 ||
      CMD_WAIT_CYC < 1 || CLEAR_WAIT_CYC < 1) begin : g_param_chk
    $error("lcd_byte_writer: every timing parameter must be >= 1");
  end

  function automatic logic [CW-1:0] ld(input int p);
    return CW'(p - 1);
  endfunction

  lcd_state_e    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d, nib_q, nib_d, lw_q, lw_d;
  logic          e_q, e_d, rsp_q, rsp_d;
  logic [3:0]    dbus_q, dbus_d;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    rs_d   = rs_q;
    nib_d  = nib_q;
    lw_d   = lw_q;
    if (st_q != S_IDLE && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      unique case (st_q)
        S_IDLE: if (req.in_valid) begin
          data_d = req.in_data;
          rs_d   = req.in_rs;
          nib_d  = req.in_nibble_only;
          lw_d   = !req.in_rs && (req.in_data == CMD_CLEAR || req.in_data == CMD_HOME ||
                                  req.in_data == 8'h03);
          st_d   = S_HI_SETUP;
          cnt_d  = ld(SETUP_CYC);
        end
        S_HI_SETUP: begin st_d = S_HI_PULSE; cnt_d = ld(E_HIGH_CYC); end
        S_HI_PULSE: begin
          // Bare init nibbles skip the low half entirely.
          if (nib_q) begin
            st_d  = S_EXEC_WAIT;
            cnt_d = lw_q ? ld(CLEAR_WAIT_CYC) : ld(CMD_WAIT_CYC);
          end else begin
            st_d  = S_GAP;
            cnt_d = ld(GAP_CYC);
          end
        end
        S_GAP:      begin st_d = S_LO_SETUP; cnt_d = ld(SETUP_CYC); end
        S_LO_SETUP: begin st_d = S_LO_PULSE; cnt_d = ld(E_HIGH_CYC); end
        S_LO_PULSE: begin
          st_d  = S_EXEC_WAIT;
          cnt_d = lw_q ? ld(CLEAR_WAIT_CYC) : ld(CMD_WAIT_CYC);
        end
        S_EXEC_WAIT: begin st_d = S_IDLE; cnt_d = '0; end
        default:     begin st_d = S_IDLE; cnt_d = '0; end
      endcase
    end

    // Pins are registered from the next state so they line up with it.
    e_d    = (st_d == S_HI_PULSE) || (st_d == S_LO_PULSE);
    rsp_d  = rsp_q;
    dbus_d = dbus_q;
    unique case (st_d)
      S_HI_SETUP, S_HI_PULSE, S_GAP: begin dbus_d = data_d[7:4]; rsp_d = rs_d; end
      S_LO_SETUP, S_LO_PULSE:        dbus_d = data_d[3:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      data_q <= '0;
      rs_q   <= 1'b0;
      nib_q  <= 1'b0;
      lw_q   <= 1'b0;
      e_q    <= 1'b0;
      rsp_q  <= 1'b0;
      dbus_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      rs_q   <= rs_d;
      nib_q  <= nib_d;
      lw_q   <= lw_d;
      e_q    <= e_d;
      rsp_q  <= rsp_d;
      dbus_q <= dbus_d;
    end
  end

  assign req.in_ready = (st_q == S_IDLE);
  assign busy         = (st_q != S_IDLE);
  assign lcd_rw       = 1'b0;
  assign lcd_e        = e_q;
  assign lcd_rs       = rsp_q;
  assign lcd_4        = dbus_q[0];
  assign lcd_5        = dbus_q[1];
  assign lcd_6        = dbus_q[2];
  assign lcd_7        = dbus_q[3];

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Bench for lcd_byte_writer: per-cycle pin trace compared to a timeline model.
module tb_lcd_byte_writer;
  localparam int SETUP = 1, EH = 2, GAP = 3, CMDW = 5, CLRW = 20;

  logic clk = 1'b0;
  logic reset;
  logic busy, lcd_rs, lcd_rw, lcd_e, lcd_4, lcd_5, lcd_6, lcd_7;
  int   checks = 0, errors = 0;

  // Expected per-cycle observation: {ready, rw, e, rs, db7..db4}
  logic [7:0] exp_q[$];

  lcd_byte_writer_if bus();

  lcd_byte_writer #(
    .SETUP_CYC(SETUP), .E_HIGH_CYC(EH), .GAP_CYC(GAP),
    .CMD_WAIT_CYC(CMDW), .CLEAR_WAIT_CYC(CLRW)
  ) dut (
    .clk(clk), .reset(reset), .req(bus), .busy(busy),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_4(lcd_4), .lcd_5(lcd_5), .lcd_6(lcd_6), .lcd_7(lcd_7)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {bus.in_ready, lcd_rw, lcd_e, lcd_rs, lcd_7, lcd_6, lcd_5, lcd_4};
  endfunction

  // Timeline of one transfer: each phase is a run of identical pin cycles,
  // followed by one idle cycle with ready high and pins holding.
  task automatic model_xfer(input logic [7:0] d, input logic rs, input logic nib);
    int w;
    logic [3:0] last;
    w    = (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? CLRW : CMDW;
    last = nib ? d[7:4] : d[3:0];
    repeat (SETUP) exp_q.push_back({3'b000, rs, d[7:4]});
    repeat (EH)    exp_q.push_back({3'b001, rs, d[7:4]});
    if (!nib) begin
      repeat (GAP)   exp_q.push_back({3'b000, rs, d[7:4]});
      repeat (SETUP) exp_q.push_back({3'b000, rs, d[3:0]});
      repeat (EH)    exp_q.push_back({3'b001, rs, d[3:0]});
    end
    repeat (w) exp_q.push_back({3'b000, rs, last});
    exp_q.push_back({3'b100, rs, last});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_rs = 1'b0; bus.in_nibble_only = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs() !== 8'b1000_0000 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got %b busy %b want 10000000 busy 0", obs(), busy);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== 8'b1000_0000 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_idle cyc %0d: got %b want 10000000", i, obs());
      end
    end
  endtask

  task automatic test_transfer(input string name, input logic [7:0] d, input logic rs,
                               input logic nib, input bit scramble, input int exp_low);
    int nbusy, low;
    exp_q.delete();
    model_xfer(d, rs, nib);
    nbusy = exp_q.size() - 1;
    low   = 0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s pre_idle: ready %b want 1", name, bus.in_ready);
    end
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_rs = rs; bus.in_nibble_only = nib;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_q[i] || busy !== !exp_q[i][7]) begin
        errors++;
        $display("FAIL %s cyc %0d: got %b busy %b want %b", name, i, obs(), busy, exp_q[i]);
      end
      if (!bus.in_ready) low++;
      if (scramble && i < nbusy) begin
        bus.in_valid = 1'($urandom); bus.in_data = 8'($urandom);
        bus.in_rs = 1'($urandom); bus.in_nibble_only = 1'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    checks++;
    if (low !== exp_low) begin
      errors++; $display("FAIL %s ready_low: got %0d cycles want %0d", name, low, exp_low);
    end
  endtask

  task automatic test_back_to_back();
    int n1;
    exp_q.delete();
    model_xfer(8'h41, 1'b1, 1'b0);
    n1 = exp_q.size() - 1;
    model_xfer(8'h42, 1'b1, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 8'h41; bus.in_rs = 1'b1; bus.in_nibble_only = 1'b0;
    @(posedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_q[i]) begin
        errors++; $display("FAIL b2b cyc %0d: got %b want %b", i, obs(), exp_q[i]);
      end
      if (i < n1)       bus.in_data = 8'($urandom);
      else if (i == n1) bus.in_data = 8'h42;
      else              bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.in_rs = 1'b1; bus.in_nibble_only = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (SETUP + 1) @(negedge clk);
    checks++;
    if (lcd_e !== 1'b1 || {lcd_7, lcd_6, lcd_5, lcd_4} !== 4'hA) begin
      errors++; $display("FAIL mid_pulse: got e %b db %b want e 1 db 1010", lcd_e, obs());
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (obs() !== 8'b1000_0000) begin
      errors++; $display("FAIL mid_reset: got %b want 10000000", obs());
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== 8'b1000_0000) begin
        errors++; $display("FAIL post_reset cyc %0d: got %b want 10000000", i, obs());
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic rs, nib;
    int lowc;
    for (int k = 0; k < 16; k++) begin
      d   = (k % 3 == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      rs  = 1'($urandom);
      nib = ($urandom_range(0, 3) == 0);
      lowc = (nib ? SETUP + EH : 2 * SETUP + 2 * EH + GAP) +
             ((!rs && d >= 8'h01 && d <= 8'h03) ? CLRW : CMDW);
      test_transfer("random", d, rs, nib, 1'b1, lowc);
    end
  endtask

  initial begin
    test_reset();
    test_transfer("byte_48",  8'h48, 1'b1, 1'b0, 1'b0, 14);
    test_transfer("clear_01", 8'h01, 1'b0, 1'b0, 1'b0, 29);
    test_transfer("data_01",  8'h01, 1'b1, 1'b0, 1'b1, 14);
    test_transfer("home_02",  8'h02, 1'b0, 1'b0, 1'b1, 29);
    test_transfer("nib_30",   8'h30, 1'b0, 1'b1, 1'b0, 8);
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
